// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter in front of an external SPI memory engine
//
// Purpose: grants one of two requesters (bit0 CPU, bit1 aux/debug) access to a
// single SPI memory engine. It latches the winner's transaction onto mem_*,
// holds mem_start until the engine completes or the timeout expires, and then
// returns one done pulse (with err) to the owner.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req[1:0]              per-requester level request
//   addr/wdata[63:0]      per-port address / write data ([31:0] port 0, [63:32] port 1)
//   nbytes[5:0]           per-port byte count ([2:0] port 0, [5:3] port 1), legal 1/2/4
//   write[1:0]            per-port direction, 1 = store
//   done/err[1:0]         per-port completion pulse and error flag
//   rdata[31:0]           captured read data
//   mem_start             level request to the engine
//   mem_addr/mem_wdata    latched transaction address / data
//   mem_nbytes/mem_write  latched byte count / direction
//   mem_done, mem_rdata   engine completion and read data
//   busy, owner           not-idle flag, id of current/last grant
module mem_arbiter #(
  parameter int TMO_W = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic [5:0]  nbytes,
  input  logic [1:0]  write,
  output logic [1:0]  done,
  output logic [1:0]  err,
  output logic [31:0] rdata,
  output logic        mem_start,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_nbytes,
  output logic        mem_write,
  input  logic        mem_done,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Counter runs 0,1,... per BUSY cycle; the cycle that sees TMO_LAST is the
  // (2^TMO_W-1)-th BUSY cycle, so the timeout fires at the end of it.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
  localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             rel_q, rel_d;     // set once the first RELEASE cycle has passed
  logic             last_q, last_d;   // last granted port, loser of the next tie
  logic             owner_q, owner_d;
  logic [1:0]       done_q, done_d;
  logic [1:0]       err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [2:0]       nbytes_q, nbytes_d;
  logic             write_q, write_d;

  logic             win;
  logic [2:0]       win_nbytes;
  logic             win_ok;

  always_comb begin
    win        = (req == 2'b11) ? ~last_q : req[1];
    win_nbytes = win ? nbytes[5:3] : nbytes[2:0];
    win_ok     = (win_nbytes == 3'd1) || (win_nbytes == 3'd2) || (win_nbytes == 3'd4);
  end

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    rel_d    = rel_q;
    last_d   = last_q;
    owner_d  = owner_q;
    done_d   = 2'b00;
    err_d    = 2'b00;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    nbytes_d = nbytes_q;
    write_d  = write_q;
    unique case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          last_d   = win;
          owner_d  = win;
          addr_d   = win ? addr[63:32]  : addr[31:0];
          wdata_d  = win ? wdata[63:32] : wdata[31:0];
          nbytes_d = win_nbytes;
          write_d  = win ? write[1] : write[0];
          tmo_d    = '0;
          rel_d    = 1'b0;
          if (win_ok) begin
            state_d = BUSY;
          end else begin
            // Illegal size never reaches the engine; report straight back.
            state_d     = RELEASE;
            done_d[win] = 1'b1;
            err_d[win]  = 1'b1;
          end
        end
      end
      BUSY: begin
        if (mem_done) begin
          rdata_d         = mem_rdata;
          state_d         = RELEASE;
          done_d[owner_q] = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          rdata_d         = 32'd0;
          state_d         = RELEASE;
          done_d[owner_q] = 1'b1;
          err_d[owner_q]  = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      RELEASE: begin
        // Minimum two cycles, then wait for the engine to drop mem_done.
        rel_d = 1'b1;
        if (rel_q && !mem_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tmo_q    <= '0;
      rel_q    <= 1'b0;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      done_q   <= 2'b00;
      err_q    <= 2'b00;
      rdata_q  <= 32'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      nbytes_q <= 3'd0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      rel_q    <= rel_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      nbytes_q <= nbytes_d;
      write_q  <= write_d;
    end
  end

  assign done       = done_q;
  assign err        = err_q;
  assign rdata      = rdata_q;
  assign mem_start  = (state_q == BUSY);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_nbytes = nbytes_q;
  assign mem_write  = write_q;
  assign busy       = (state_q != IDLE);
  assign owner      = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  req, req_t;
  logic [63:0] addr, wdata;
  logic [5:0]  nbytes;
  logic [1:0]  write;
  logic        mem_done, mem_done_t;
  logic [31:0] mem_rdata, mem_rdata_t;

  logic [1:0]  done, err, done_t, err_t;
  logic [31:0] rdata, rdata_t, mem_addr, mem_addr_t, mem_wdata, mem_wdata_t;
  logic        mem_start, mem_start_t, mem_write, mem_write_t;
  logic [2:0]  mem_nbytes, mem_nbytes_t;
  logic        busy, busy_t, owner, owner_t;

  mem_arbiter #(.TMO_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .wdata(wdata), .nbytes(nbytes),
    .write(write), .done(done), .err(err), .rdata(rdata), .mem_start(mem_start),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_nbytes(mem_nbytes), .mem_write(mem_write),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  mem_arbiter #(.TMO_W(4)) dut_t (
    .clk(clk), .rst_n(rst_n), .req(req_t), .addr(addr), .wdata(wdata), .nbytes(nbytes),
    .write(write), .done(done_t), .err(err_t), .rdata(rdata_t), .mem_start(mem_start_t),
    .mem_addr(mem_addr_t), .mem_wdata(mem_wdata_t), .mem_nbytes(mem_nbytes_t), .mem_write(mem_write_t),
    .mem_done(mem_done_t), .mem_rdata(mem_rdata_t), .busy(busy_t), .owner(owner_t)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Engine model: raises mem_done eng_lat cycles into mem_start, keeps it
  // up until eng_hold cycles after mem_start falls.
  int          eng_lat  = 1;
  int          eng_hold = 0;
  logic [31:0] eng_data = 32'd0;

  initial begin
    int cnt;
    int hcnt;
    mem_done  = 1'b0;
    mem_rdata = 32'd0;
    cnt  = 0;
    hcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_done = 1'b0;
        cnt      = 0;
        hcnt     = 0;
      end else if (!mem_done) begin
        if (mem_start) begin
          cnt++;
          if (cnt >= eng_lat) begin
            mem_done  = 1'b1;
            mem_rdata = eng_data;
            cnt       = 0;
            hcnt      = 0;
          end
        end else begin
          cnt = 0;
        end
      end else if (!mem_start) begin
        if (hcnt >= eng_hold) mem_done = 1'b0;
        else hcnt++;
      end
    end
  end

  // Results of the last transaction run by run_txn.
  logic [1:0]  r_done, r_err;
  logic        r_owner;
  logic [31:0] r_rdata, s_addr, s_wdata;
  logic [2:0]  s_nb;
  logic        s_wr, r_proto_ok, r_fin;
  int          r_starts, r_done_idx, r_done_cnt, r_rel;

  task automatic run_txn(input logic [1:0] r, input int lat, input logic [31:0] data, input int hold);
    logic seen_busy, seen_done;
    r_done = 0; r_err = 0; r_owner = 0; r_rdata = 0;
    s_addr = 0; s_wdata = 0; s_nb = 0; s_wr = 0;
    r_starts = 0; r_done_idx = 0; r_done_cnt = 0; r_rel = 0;
    r_proto_ok = 1'b1; r_fin = 1'b0;
    seen_busy = 1'b0; seen_done = 1'b0;
    eng_lat = lat; eng_data = data; eng_hold = hold;
    req = r;
    for (int idx = 1; idx <= 3000 && !r_fin; idx++) begin
      @(negedge clk);
      if ((done == 2'b00) && (err != 2'b00)) r_proto_ok = 1'b0;
      if (busy) begin
        if (!seen_busy) begin
          seen_busy = 1'b1;
          s_addr = mem_addr; s_wdata = mem_wdata; s_nb = mem_nbytes; s_wr = mem_write;
        end else if (mem_addr !== s_addr || mem_wdata !== s_wdata ||
                     mem_nbytes !== s_nb || mem_write !== s_wr) begin
          r_proto_ok = 1'b0;
        end
        addr   = {$urandom, $urandom};
        wdata  = {$urandom, $urandom};
        nbytes = 6'($urandom);
        write  = 2'($urandom);
      end
      if (mem_start) r_starts++;
      if (done != 2'b00) begin
        r_done_cnt++;
        if (!seen_done) begin
          seen_done = 1'b1;
          r_done_idx = idx;
          r_done = done; r_err = err; r_owner = owner; r_rdata = rdata;
          req = 2'b00;
        end
      end
      if (seen_done && busy) r_rel++;
      if (seen_busy && !busy) r_fin = 1'b1;
    end
  endtask

  task automatic check_txn(input string tag, input logic [1:0] e_done, input logic [1:0] e_err,
                           input logic e_owner, input logic [31:0] e_rdata, input int e_lat,
                           input logic [31:0] e_addr, input logic [31:0] e_wdata,
                           input logic [2:0] e_nb, input logic e_wr);
    logic ok;
    ok = (e_err == 2'b00);
    chk({tag, "_finished"}, r_fin, 1);
    chk({tag, "_done"}, r_done, e_done);
    chk({tag, "_err"}, r_err, e_err);
    chk({tag, "_owner"}, r_owner, e_owner);
    chk({tag, "_rdata"}, r_rdata, e_rdata);
    chk({tag, "_start_cycles"}, r_starts, ok ? e_lat : 0);
    chk({tag, "_done_latency"}, r_done_idx, ok ? e_lat + 1 : 1);
    chk({tag, "_done_once"}, r_done_cnt, 1);
    chk({tag, "_release_min2"}, (r_rel >= 2), 1);
    chk({tag, "_stable_noerr"}, r_proto_ok, 1);
    chk({tag, "_mem_addr"}, s_addr, e_addr);
    chk({tag, "_mem_wdata"}, s_wdata, e_wdata);
    chk({tag, "_mem_nbytes"}, s_nb, e_nb);
    chk({tag, "_mem_write"}, s_wr, e_wr);
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [31:0] a0, a1, w0, w1;
    logic [2:0]  nb0, nb1;
    logic [1:0]  wr;
    int          lat;
    int          hold;
    logic [31:0] data;
    logic [1:0]  exp_done, exp_err;
    logic        exp_owner;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt[10];

  initial begin
    logic        win, last_m, valid, fin, seen, nodone;
    logic [31:0] rd_m, a0, a1, w0, w1, dat;
    logic [2:0]  nb0, nb1;
    logic [1:0]  r, wr, td, te;
    logic [31:0] tr;
    logic        to;
    int          k, lat, hold;

    vt[0] = '{2'b11, 32'h100,      32'h200,      32'hA0, 32'hB0, 3'd1, 3'd2, 2'b00, 3,  0, 32'h11111111, 2'b01, 2'b00, 1'b0, 32'h11111111};
    vt[1] = '{2'b11, 32'h104,      32'h204,      32'hA1, 32'hB1, 3'd2, 3'd4, 2'b10, 5,  1, 32'h22222222, 2'b10, 2'b00, 1'b1, 32'h22222222};
    vt[2] = '{2'b11, 32'h108,      32'h208,      32'hA2, 32'hB2, 3'd4, 3'd1, 2'b00, 2,  2, 32'h33333333, 2'b01, 2'b00, 1'b0, 32'h33333333};
    vt[3] = '{2'b10, 32'h10C,      32'h20C,      32'hA3, 32'hB3, 3'd4, 3'd3, 2'b00, 4,  0, 32'h44444444, 2'b10, 2'b10, 1'b1, 32'h33333333};
    vt[4] = '{2'b01, 32'h100,      32'h210,      32'hA4, 32'hB4, 3'd4, 3'd2, 2'b00, 20, 0, 32'hDEADBEEF, 2'b01, 2'b00, 1'b0, 32'hDEADBEEF};
    vt[5] = '{2'b01, 32'h114,      32'h214,      32'h12345678, 32'hB5, 3'd2, 3'd1, 2'b01, 8, 3, 32'h5A5A5A5A, 2'b01, 2'b00, 1'b0, 32'h5A5A5A5A};
    vt[6] = '{2'b11, 32'h118,      32'h218,      32'hA6, 32'hB6, 3'd4, 3'd1, 2'b10, 1,  0, 32'h66666666, 2'b10, 2'b00, 1'b1, 32'h66666666};
    vt[7] = '{2'b01, 32'h11C,      32'h21C,      32'hA7, 32'hB7, 3'd5, 3'd1, 2'b00, 4,  0, 32'h77777777, 2'b01, 2'b01, 1'b0, 32'h66666666};
    vt[8] = '{2'b11, 32'h120,      32'h220,      32'hA8, 32'hB8, 3'd1, 3'd0, 2'b00, 4,  0, 32'h88888888, 2'b10, 2'b10, 1'b1, 32'h66666666};
    vt[9] = '{2'b11, 32'h124,      32'h224,      32'hA9, 32'hB9, 3'd4, 3'd4, 2'b01, 1,  0, 32'h99999999, 2'b01, 2'b00, 1'b0, 32'h99999999};

    req = 2'b00; req_t = 2'b00; addr = '0; wdata = '0; nbytes = '0; write = '0;
    mem_done_t = 1'b0; mem_rdata_t = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_start", mem_start, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_nbytes", mem_nbytes, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_owner", owner, 0);
    chk("rst_t_busy", busy_t, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table from reset: tie order, invalid sizes, single load, store.
    for (int i = 0; i < 10; i++) begin
      addr   = {vt[i].a1, vt[i].a0};
      wdata  = {vt[i].w1, vt[i].w0};
      nbytes = {vt[i].nb1, vt[i].nb0};
      write  = vt[i].wr;
      run_txn(vt[i].req, vt[i].lat, vt[i].data, vt[i].hold);
      win = vt[i].exp_owner;
      check_txn($sformatf("vec%0d", i), vt[i].exp_done, vt[i].exp_err, vt[i].exp_owner,
                vt[i].exp_rdata, vt[i].lat, win ? vt[i].a1 : vt[i].a0,
                win ? vt[i].w1 : vt[i].w0, win ? vt[i].nb1 : vt[i].nb0, vt[i].wr[win]);
    end

    // Short-timeout instance: one normal load, then a timeout.
    @(negedge clk);
    nbytes = {3'd4, 3'd4};
    req_t = 2'b10;
    fin = 1'b0; seen = 1'b0; k = 0; td = 0; te = 0; tr = 0; to = 0;
    for (int i = 0; i < 60 && !fin; i++) begin
      @(negedge clk);
      if (mem_start_t) begin
        k++;
        if (k == 3) begin mem_done_t = 1'b1; mem_rdata_t = 32'hCAFEF00D; end
      end else if (mem_done_t) begin
        mem_done_t = 1'b0;
      end
      if (done_t != 2'b00 && !seen) begin
        seen = 1'b1; td = done_t; te = err_t; tr = rdata_t; to = owner_t; req_t = 2'b00;
      end
      if (seen && !busy_t) fin = 1'b1;
    end
    chk("t_load_finished", fin, 1);
    chk("t_load_done", td, 2'b10);
    chk("t_load_err", te, 2'b00);
    chk("t_load_rdata", tr, 32'hCAFEF00D);
    chk("t_load_owner", to, 1);

    mem_done_t = 1'b0;
    req_t = 2'b01;
    fin = 1'b0; seen = 1'b0; k = 0; td = 0; te = 0; tr = 32'hFFFFFFFF; to = 1;
    for (int i = 0; i < 100 && !fin; i++) begin
      @(negedge clk);
      if (mem_start_t) k++;
      if (done_t != 2'b00 && !seen) begin
        seen = 1'b1; td = done_t; te = err_t; tr = rdata_t; to = owner_t; req_t = 2'b00;
      end
      if (seen && !busy_t) fin = 1'b1;
    end
    chk("tmo_finished", fin, 1);
    chk("tmo_start_cycles", k, 15);
    chk("tmo_done", td, 2'b01);
    chk("tmo_err", te, 2'b01);
    chk("tmo_rdata", tr, 0);
    chk("tmo_owner", to, 0);

    // Reset five cycles into BUSY.
    @(negedge clk);
    nbytes = {3'd1, 3'd4};
    eng_lat = 100;
    req = 2'b01;
    k = 0;
    for (int i = 0; i < 20 && k < 5; i++) begin
      @(negedge clk);
      if (mem_start) k++;
    end
    chk("rstbusy_reached", k, 5);
    req = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    chk("rstbusy_mem_start", mem_start, 0);
    chk("rstbusy_busy", busy, 0);
    chk("rstbusy_done", done, 0);
    nodone = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (done != 2'b00) nodone = 1'b0;
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (done != 2'b00 || busy) nodone = 1'b0;
    end
    chk("rstbusy_no_done_idle", nodone, 1);
    chk("rstbusy_owner", owner, 0);
    chk("rstbusy_mem_addr", mem_addr, 0);

    // Random transactions against a transaction-level model.
    last_m = 1'b1;
    rd_m   = 32'd0;
    for (int n = 0; n < 40; n++) begin
      r   = 2'($urandom_range(1, 3));
      a0  = $urandom; a1 = $urandom; w0 = $urandom; w1 = $urandom;
      nb0 = ($urandom_range(0, 3) != 0) ? 3'(1 << $urandom_range(0, 2)) : 3'($urandom);
      nb1 = ($urandom_range(0, 3) != 0) ? 3'(1 << $urandom_range(0, 2)) : 3'($urandom);
      wr  = 2'($urandom);
      lat = $urandom_range(1, 12);
      hold = $urandom_range(0, 3);
      dat = $urandom;
      win = (r == 2'b11) ? ~last_m : r[1];
      last_m = win;
      valid = win ? (nb1 == 1 || nb1 == 2 || nb1 == 4) : (nb0 == 1 || nb0 == 2 || nb0 == 4);
      if (valid) rd_m = dat;
      addr = {a1, a0}; wdata = {w1, w0}; nbytes = {nb1, nb0}; write = wr;
      run_txn(r, lat, dat, hold);
      check_txn($sformatf("rnd%0d", n), 2'(1 << win), valid ? 2'b00 : 2'(1 << win), win, rd_m,
                lat, win ? a1 : a0, win ? w1 : w0, win ? nb1 : nb0, wr[win]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
